// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver FSM states
// and the oversampling divider calculation.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    // Clocks per oversampling tick, never below one.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned d;
        d = clk_hz / (baud * os);
        return (d == 0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two >= 2.
// Simultaneous push and pop are both honoured, even when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         dout
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign count   = count_q;
    // Head word reads as zero while empty so the output is defined out of reset.
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with self-generated oversampling tick, majority-voted
// mid-bit sampling, parity/framing checks and a buffered valid/ready output stream.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_data,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          rx_busy
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
    localparam int unsigned MID   = OVERSAMPLE / 2;
    localparam int unsigned CNT_W = 4;

    logic                 rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0]     div_q;
    logic                 tick, mid_tick, maj, stop_low;
    logic [PH_W-1:0]      phase_q, phase_d;
    rx_state_e            state_q, state_d;
    logic                 armed_q, armed_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign tick     = (div_q == DIV_W'(DIV - 1));
    assign mid_tick = tick && (phase_q == PH_W'(MID + 1));
    // Third vote is the live synchronised value at the last sample tick.
    assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q)
                    | (samp_q[1] & rx_sync_q);
    assign stop_low = stop_bad_q | ~maj;

    assign m_valid    = ~fifo_empty;
    assign fifo_pop   = m_valid && m_ready;
    assign rx_busy    = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        armed_d      = armed_q | rx_sync_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        fifo_push    = 1'b0;

        if (tick) begin
            phase_d = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_q + 1'b1;
            if (phase_q == PH_W'(MID - 1)) samp_d[0] = rx_sync_q;
            if (phase_q == PH_W'(MID))     samp_d[1] = rx_sync_q;
        end

        case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_sync_q) begin
                    phase_d = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (mid_tick) begin
                    if (maj) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        bit_cnt_d  = '0;
                        par_bad_d  = 1'b0;
                        stop_bad_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (mid_tick) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (mid_tick) begin
                    par_bad_d = ((^shift_q) ^ maj) != (PARITY == PAR_ODD);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (mid_tick) begin
                    if (bit_cnt_q == CNT_W'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        if (stop_low) begin
                            frame_err_d = 1'b1;
                            armed_d     = 1'b0;
                        end else if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else if (fifo_full && !fifo_pop) begin
                            overrun_d = 1'b1;
                        end else begin
                            fifo_push = 1'b1;
                        end
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        stop_bad_d = stop_low;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            div_q        <= '0;
            phase_q      <= '0;
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            samp_q       <= '0;
            shift_q      <= '1;
            bit_cnt_q    <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_data;
            rx_sync_q    <= rx_meta_q;
            div_q        <= tick ? '0 : div_q + 1'b1;
            phase_q      <= phase_d;
            state_q      <= state_d;
            armed_q      <= armed_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (shift_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .dout  (m_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: three receivers (8N1 for overrun, 7E1 for parity, 8N1 for the rest)
// driven in parallel at 625 kbaud from a 100 MHz clock (160 clk per bit).
module tb_uart_rx_fifo;

    localparam int BIT_CLK   = 160;
    localparam int FRAME_CLK = 10 * BIT_CLK;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       rx_a, rx_b, rx_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] md_a, md_c;
    logic [6:0] md_b;
    logic       mv_a, mv_b, mv_c;
    logic [5:0] cnt_a, cnt_b, cnt_c;
    logic       fe_a, fe_b, fe_c, pe_a, pe_b, pe_c, ov_a, ov_b, ov_c;
    logic       busy_a, busy_b, busy_c;

    uart_rx_fifo #(.CLK_HZ(100000000), .BAUD(625000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(32)) u_dut_a (
        .clk(clk), .reset(rst_a), .rx_data(rx_a), .m_data(md_a), .m_valid(mv_a),
        .m_ready(rdy_a), .fifo_count(cnt_a), .frame_err(fe_a), .parity_err(pe_a),
        .overrun(ov_a), .rx_busy(busy_a));

    uart_rx_fifo #(.CLK_HZ(100000000), .BAUD(625000), .OVERSAMPLE(16), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(32)) u_dut_b (
        .clk(clk), .reset(rst_b), .rx_data(rx_b), .m_data(md_b), .m_valid(mv_b),
        .m_ready(rdy_b), .fifo_count(cnt_b), .frame_err(fe_b), .parity_err(pe_b),
        .overrun(ov_b), .rx_busy(busy_b));

    uart_rx_fifo #(.CLK_HZ(100000000), .BAUD(625000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(32)) u_dut_c (
        .clk(clk), .reset(rst_c), .rx_data(rx_c), .m_data(md_c), .m_valid(mv_c),
        .m_ready(rdy_c), .fifo_count(cnt_c), .frame_err(fe_c), .parity_err(pe_c),
        .overrun(ov_c), .rx_busy(busy_c));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitors sample on the falling edge; stimulus changes just after the rising edge.
    logic [7:0] q_a[$];
    logic [7:0] q_c[$];
    int ferr_a = 0, perr_a = 0, ovr_a = 0;
    int ferr_b = 0, perr_b = 0, ovr_b = 0;
    int ferr_c = 0, perr_c = 0, ovr_c = 0;
    int busy_rise_c = 0, max_cnt_c = 0;
    logic busy_c_prev = 1'b0;

    always @(negedge clk) begin
        if (mv_a && rdy_a) q_a.push_back(md_a);
        if (mv_c && rdy_c) q_c.push_back(md_c);
        ferr_a += int'(fe_a); perr_a += int'(pe_a); ovr_a += int'(ov_a);
        ferr_b += int'(fe_b); perr_b += int'(pe_b); ovr_b += int'(ov_b);
        ferr_c += int'(fe_c); perr_c += int'(pe_c); ovr_c += int'(ov_c);
        if (busy_c && !busy_c_prev) busy_rise_c++;
        busy_c_prev = busy_c;
        if (int'(cnt_c) > max_cnt_c) max_cnt_c = int'(cnt_c);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int ln, input logic v);
        case (ln)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // par: 0 none, 1 odd, 2 even. Line is left at the stop-bit level.
    task automatic send_frame(input int ln, input logic [8:0] data, input int nbits,
                              input int par, input logic flip, input logic stop);
        logic p;
        set_line(ln, 1'b0);
        wait_clks(BIT_CLK);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            set_line(ln, data[i]);
            p ^= data[i];
            wait_clks(BIT_CLK);
        end
        if (par != 0) begin
            if (par == 1) p = ~p;
            set_line(ln, p ^ flip);
            wait_clks(BIT_CLK);
        end
        set_line(ln, stop);
        wait_clks(BIT_CLK);
    endtask

    logic [7:0] t1_bytes [18] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3,
                                  8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd8, 8'd6, 8'd7};

    task automatic test_overrun();
        for (int i = 0; i < 33; i++) begin
            send_frame(0, 9'(i), 8, 0, 1'b0, 1'b1);
            if (i == 31) begin
                check("ovr_count_full", 32'(cnt_a), 32'd32);
                check("ovr_none_yet", 32'(ovr_a), 32'd0);
            end
        end
        check("ovr_pulse", 32'(ovr_a), 32'd1);
        check("ovr_count_held", 32'(cnt_a), 32'd32);
        rdy_a = 1'b1;
        wait_clks(40);
        check("ovr_drained", 32'(q_a.size()), 32'd32);
        for (int i = 0; i < 32; i++)
            check($sformatf("ovr_word%0d", i),
                  (i < q_a.size()) ? 32'(q_a[i]) : 32'hFFFF_FFFF, 32'(i));
        check("ovr_count_empty", 32'(cnt_a), 32'd0);
        check("ovr_other_errs", 32'(ferr_a + perr_a), 32'd0);
    endtask

    task automatic test_parity();
        send_frame(1, 9'h55, 7, 2, 1'b0, 1'b1);
        send_frame(1, 9'h55, 7, 2, 1'b1, 1'b1);
        wait_clks(BIT_CLK);
        check("par_count", 32'(cnt_b), 32'd1);
        check("par_head", 32'(md_b), 32'h55);
        check("par_err_pulse", 32'(perr_b), 32'd1);
        check("par_no_ferr", 32'(ferr_b + ovr_b), 32'd0);
    endtask

    task automatic test_main();
        int snap_busy, snap_ferr;
        // Back-to-back 8N1 stream with a ready consumer.
        for (int i = 0; i < 18; i++) send_frame(2, {1'b0, t1_bytes[i]}, 8, 0, 1'b0, 1'b1);
        wait_clks(BIT_CLK);
        check("t1_words", 32'(q_c.size()), 32'd18);
        for (int i = 0; i < 18; i++)
            check($sformatf("t1_word%0d", i),
                  (i < q_c.size()) ? 32'(q_c[i]) : 32'hFFFF_FFFF, 32'(t1_bytes[i]));
        check("t1_max_count", 32'(max_cnt_c), 32'd1);
        check("t1_no_errs", 32'(ferr_c + perr_c + ovr_c), 32'd0);
        q_c.delete();

        // Framing error followed by a held-low line.
        send_frame(2, 9'hA3, 8, 0, 1'b0, 1'b0);
        check("fe_pulse", 32'(ferr_c), 32'd1);
        snap_busy = busy_rise_c;
        wait_clks(3 * FRAME_CLK);
        check("fe_single", 32'(ferr_c), 32'd1);
        check("fe_no_rearm", 32'(busy_rise_c), 32'(snap_busy));
        check("fe_idle", 32'(busy_c), 32'd0);
        check("fe_no_push", 32'(q_c.size() + int'(cnt_c)), 32'd0);
        set_line(2, 1'b1);
        wait_clks(2 * BIT_CLK);
        send_frame(2, 9'h3C, 8, 0, 1'b0, 1'b1);
        wait_clks(BIT_CLK);
        check("fe_recover_n", 32'(q_c.size()), 32'd1);
        check("fe_recover_word", (q_c.size() > 0) ? 32'(q_c[0]) : 32'hFFFF_FFFF, 32'h3C);
        q_c.delete();

        // Short low glitch is rejected as a false start.
        snap_busy = busy_rise_c;
        snap_ferr = ferr_c + perr_c + ovr_c;
        set_line(2, 1'b0);
        wait_clks(40);
        set_line(2, 1'b1);
        wait_clks(300);
        check("gl_busy_pulse", 32'(busy_rise_c), 32'(snap_busy + 1));
        check("gl_busy_clear", 32'(busy_c), 32'd0);
        check("gl_no_push", 32'(q_c.size() + int'(cnt_c)), 32'd0);
        check("gl_no_err", 32'(ferr_c + perr_c + ovr_c), 32'(snap_ferr));

        // Reset mid-frame with buffered words.
        rdy_c = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(2, 9'(8'h11 * i), 8, 0, 1'b0, 1'b1);
        check("rs_count5", 32'(cnt_c), 32'd5);
        check("rs_head", 32'(md_c), 32'h11);
        set_line(2, 1'b0);
        wait_clks(BIT_CLK);
        set_line(2, 1'b1);
        wait_clks(BIT_CLK + BIT_CLK / 2);
        check("rs_busy_mid", 32'(busy_c), 32'd1);
        rst_c = 1'b1;
        wait_clks(1);
        check("rs_valid", 32'(mv_c), 32'd0);
        check("rs_count", 32'(cnt_c), 32'd0);
        check("rs_busy", 32'(busy_c), 32'd0);
        rst_c = 1'b0;
        rdy_c = 1'b1;
        q_c.delete();
        wait_clks(2 * BIT_CLK);
        send_frame(2, 9'h81, 8, 0, 1'b0, 1'b1);
        wait_clks(BIT_CLK);
        check("rs_after_n", 32'(q_c.size()), 32'd1);
        check("rs_after_word", (q_c.size() > 0) ? 32'(q_c[0]) : 32'hFFFF_FFFF, 32'h81);
    endtask

    initial begin
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        wait_clks(3);
        check("rst_valid", 32'(mv_c), 32'd0);
        check("rst_count", 32'(cnt_c), 32'd0);
        check("rst_data", 32'(md_c), 32'd0);
        check("rst_busy", 32'(busy_c), 32'd0);
        check("rst_pulses", 32'({fe_c, pe_c, ov_c}), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        wait_clks(BIT_CLK);
        fork
            test_overrun();
            test_parity();
            test_main();
        join
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
